id_ex_stage: RTL and testbench

//   ID/EX pipeline register and operand-forwarding stage that feeds the ALU.

---
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back capture bypass, MEM/WB operand forwarding,
// ALU operand selection and load-use hazard detection.
module id_ex_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1Data,
    input  logic [XLEN-1:0]    id_rs2Data,
    input  logic [XLEN-1:0]    id_immExt,
    input  logic [RADDR_W-1:0] id_rs1Addr,
    input  logic [RADDR_W-1:0] id_rs2Addr,
    input  logic [RADDR_W-1:0] id_rdAddr,
    input  logic [3:0]         id_ALUControl,
    input  logic [1:0]         id_ALUSrcA,
    input  logic               id_ALUSrcB,
    input  logic               id_regWrite,
    input  logic               id_memRead,
    input  logic               mem_regWrite,
    input  logic [RADDR_W-1:0] mem_rdAddr,
    input  logic [XLEN-1:0]    mem_ALUResult,
    input  logic               wb_regWrite,
    input  logic [RADDR_W-1:0] wb_rdAddr,
    input  logic [XLEN-1:0]    wb_result,
    output logic [XLEN-1:0]    srcA,
    output logic [XLEN-1:0]    srcB,
    output logic [3:0]         ALUControl,
    output logic [XLEN-1:0]    ex_storeData,
    output logic               ex_valid,
    output logic               ex_regWrite,
    output logic               ex_memRead,
    output logic [RADDR_W-1:0] ex_rdAddr,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_immExt,
    output logic               loadUseHazard
);

    localparam logic [RADDR_W-1:0] REG_ZERO = RADDR_W'(0);

    logic [XLEN-1:0]    ex_rs1_data;
    logic [XLEN-1:0]    ex_rs2_data;
    logic [RADDR_W-1:0] ex_rs1_addr;
    logic [RADDR_W-1:0] ex_rs2_addr;
    logic [1:0]         ex_alu_src_a;
    logic               ex_alu_src_b;

    logic               wb_cap1;
    logic               wb_cap2;
    logic [XLEN-1:0]    cap_rs1;
    logic [XLEN-1:0]    cap_rs2;

    // A WB write landing this cycle is not yet visible in the regfile read data
    assign wb_cap1 = wb_regWrite && (wb_rdAddr != REG_ZERO) && (wb_rdAddr == id_rs1Addr);
    assign wb_cap2 = wb_regWrite && (wb_rdAddr != REG_ZERO) && (wb_rdAddr == id_rs2Addr);
    assign cap_rs1 = wb_cap1 ? wb_result : id_rs1Data;
    assign cap_rs2 = wb_cap2 ? wb_result : id_rs2Data;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_immExt    <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rdAddr    <= '0;
            ALUControl   <= 4'd0;
            ex_alu_src_a <= 2'd0;
            ex_alu_src_b <= 1'b0;
            ex_regWrite  <= 1'b0;
            ex_memRead   <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1_data  <= cap_rs1;
            ex_rs2_data  <= cap_rs2;
            ex_immExt    <= id_immExt;
            ex_rs1_addr  <= id_rs1Addr;
            ex_rs2_addr  <= id_rs2Addr;
            ex_rdAddr    <= id_rdAddr;
            ALUControl   <= id_ALUControl;
            ex_alu_src_a <= id_ALUSrcA;
            ex_alu_src_b <= id_ALUSrcB;
            ex_regWrite  <= id_regWrite;
            ex_memRead   <= id_memRead;
        end
    end

    logic            mem_hit1;
    logic            mem_hit2;
    logic            wb_hit1;
    logic            wb_hit2;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    assign mem_hit1 = mem_regWrite && (mem_rdAddr != REG_ZERO) && (mem_rdAddr == ex_rs1_addr);
    assign mem_hit2 = mem_regWrite && (mem_rdAddr != REG_ZERO) && (mem_rdAddr == ex_rs2_addr);
    assign wb_hit1  = wb_regWrite  && (wb_rdAddr  != REG_ZERO) && (wb_rdAddr  == ex_rs1_addr);
    assign wb_hit2  = wb_regWrite  && (wb_rdAddr  != REG_ZERO) && (wb_rdAddr  == ex_rs2_addr);

    // MEM holds the younger result, so it wins over WB
    always_comb begin
        fwd1 = ex_rs1_data;
        fwd2 = ex_rs2_data;
        if (mem_hit1) begin
            fwd1 = mem_ALUResult;
        end else if (wb_hit1) begin
            fwd1 = wb_result;
        end
        if (mem_hit2) begin
            fwd2 = mem_ALUResult;
        end else if (wb_hit2) begin
            fwd2 = wb_result;
        end
    end

    always_comb begin
        srcA = '0;
        case (ex_alu_src_a)
            2'd0:    srcA = fwd1;
            2'd1:    srcA = ex_pc;
            default: srcA = '0;
        endcase
    end

    assign srcB         = ex_alu_src_b ? ex_immExt : fwd2;
    assign ex_storeData = fwd2;

    assign loadUseHazard = ex_valid && ex_memRead && (ex_rdAddr != REG_ZERO) &&
                           ((ex_rdAddr == id_rs1Addr) || (ex_rdAddr == id_rs2Addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// transaction-level reference of the EX stage contents.
module tb_id_ex_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;

    logic               clk;
    logic               reset, stall, flush;
    logic               id_valid;
    logic [XLEN-1:0]    id_pc, id_rs1Data, id_rs2Data, id_immExt;
    logic [RADDR_W-1:0] id_rs1Addr, id_rs2Addr, id_rdAddr;
    logic [3:0]         id_ALUControl;
    logic [1:0]         id_ALUSrcA;
    logic               id_ALUSrcB, id_regWrite, id_memRead;
    logic               mem_regWrite;
    logic [RADDR_W-1:0] mem_rdAddr;
    logic [XLEN-1:0]    mem_ALUResult;
    logic               wb_regWrite;
    logic [RADDR_W-1:0] wb_rdAddr;
    logic [XLEN-1:0]    wb_result;
    logic [XLEN-1:0]    srcA, srcB, ex_storeData, ex_pc, ex_immExt;
    logic [3:0]         ALUControl;
    logic               ex_valid, ex_regWrite, ex_memRead, loadUseHazard;
    logic [RADDR_W-1:0] ex_rdAddr;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1Data(id_rs1Data),
        .id_rs2Data(id_rs2Data), .id_immExt(id_immExt), .id_rs1Addr(id_rs1Addr),
        .id_rs2Addr(id_rs2Addr), .id_rdAddr(id_rdAddr), .id_ALUControl(id_ALUControl),
        .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB), .id_regWrite(id_regWrite),
        .id_memRead(id_memRead), .mem_regWrite(mem_regWrite), .mem_rdAddr(mem_rdAddr),
        .mem_ALUResult(mem_ALUResult), .wb_regWrite(wb_regWrite), .wb_rdAddr(wb_rdAddr),
        .wb_result(wb_result), .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl),
        .ex_storeData(ex_storeData), .ex_valid(ex_valid), .ex_regWrite(ex_regWrite),
        .ex_memRead(ex_memRead), .ex_rdAddr(ex_rdAddr), .ex_pc(ex_pc),
        .ex_immExt(ex_immExt), .loadUseHazard(loadUseHazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction currently sitting in EX, as the reference sees it
    typedef struct {
        logic               valid;
        logic [XLEN-1:0]    pc, v1, v2, imm;
        logic [RADDR_W-1:0] rs1, rs2, rd;
        logic [3:0]         op;
        logic [1:0]         sa;
        logic               sb, rw, mr;
    } ex_insn_t;

    ex_insn_t        m;
    logic [XLEN-1:0] regs [8];

    function automatic ex_insn_t bubble();
        ex_insn_t b;
        b.valid = 1'b0; b.pc = '0; b.v1 = '0; b.v2 = '0; b.imm = '0;
        b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.op = 4'd0; b.sa = 2'd0;
        b.sb = 1'b0; b.rw = 1'b0; b.mr = 1'b0;
        return b;
    endfunction

    // Value a source register really holds when ID reads it (a WB write this cycle counts)
    function automatic logic [XLEN-1:0] id_read(logic [RADDR_W-1:0] a, logic [XLEN-1:0] rf);
        if (wb_regWrite && a != 0 && a == wb_rdAddr) return wb_result;
        return rf;
    endfunction

    function automatic ex_insn_t model_next();
        ex_insn_t n;
        if (reset || flush) return bubble();
        if (stall) return m;
        n.valid = id_valid; n.pc = id_pc; n.imm = id_immExt;
        n.v1 = id_read(id_rs1Addr, id_rs1Data);
        n.v2 = id_read(id_rs2Addr, id_rs2Data);
        n.rs1 = id_rs1Addr; n.rs2 = id_rs2Addr; n.rd = id_rdAddr;
        n.op = id_ALUControl; n.sa = id_ALUSrcA; n.sb = id_ALUSrcB;
        n.rw = id_regWrite; n.mr = id_memRead;
        return n;
    endfunction

    // Newest in-flight value of register a, falling back to what EX captured
    function automatic logic [XLEN-1:0] newest(logic [RADDR_W-1:0] a, logic [XLEN-1:0] v);
        if (a == 0) return v;
        if (mem_regWrite && mem_rdAddr == a) return mem_ALUResult;
        if (wb_regWrite && wb_rdAddr == a) return wb_result;
        return v;
    endfunction

    task automatic tick();
        ex_insn_t nxt;
        nxt = model_next();
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_rs1Data = '0; id_rs2Data = '0; id_immExt = '0;
        id_rs1Addr = '0; id_rs2Addr = '0; id_rdAddr = '0; id_ALUControl = 4'd0;
        id_ALUSrcA = 2'd0; id_ALUSrcB = 1'b0; id_regWrite = 1'b0; id_memRead = 1'b0;
        mem_regWrite = 1'b0; mem_rdAddr = '0; mem_ALUResult = '0;
        wb_regWrite = 1'b0; wb_rdAddr = '0; wb_result = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        id_valid = 1'b1; id_regWrite = 1'b1; id_ALUControl = 4'd5; id_pc = 32'h40;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (srcA !== 32'h0)    begin errors++; $display("FAIL reset_srcA got=%h exp=0", srcA); end
        checks++; if (srcB !== 32'h0)    begin errors++; $display("FAIL reset_srcB got=%h exp=0", srcB); end
        checks++; if (ALUControl !== 4'd0) begin errors++; $display("FAIL reset_alu got=%0d exp=0", ALUControl); end
        checks++; if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0 || ex_pc !== 32'h0)
            begin errors++; $display("FAIL reset_ctrl got=%b%b pc=%h exp=00 pc=0", ex_valid, ex_regWrite, ex_pc); end
        reset = 1'b0;
    endtask

    task automatic test_basic_load();
        idle_inputs();
        id_valid = 1'b1; id_rs1Addr = 5'd1; id_rs2Addr = 5'd2; id_rdAddr = 5'd3;
        id_rs1Data = 32'd5; id_rs2Data = 32'd7; id_ALUControl = 4'd1; id_regWrite = 1'b1;
        tick();
        checks++; if (srcA !== 32'd5) begin errors++; $display("FAIL basic_srcA got=%0d exp=5", srcA); end
        checks++; if (srcB !== 32'd7) begin errors++; $display("FAIL basic_srcB got=%0d exp=7", srcB); end
        checks++; if (ALUControl !== 4'd1 || ex_valid !== 1'b1 || ex_rdAddr !== 5'd3)
            begin errors++; $display("FAIL basic_ctrl got=%0d/%b/%0d exp=1/1/3", ALUControl, ex_valid, ex_rdAddr); end
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        id_valid = 1'b1; id_rs1Addr = 5'd3; id_rs2Addr = 5'd3; id_rs1Data = 32'h11; id_rs2Data = 32'h11;
        tick();
        mem_regWrite = 1'b1; mem_rdAddr = 5'd3; mem_ALUResult = 32'hAA;
        wb_regWrite = 1'b1; wb_rdAddr = 5'd3; wb_result = 32'hBB;
        #1;
        checks++; if (srcA !== 32'hAA) begin errors++; $display("FAIL fwd_mem_srcA got=%h exp=aa", srcA); end
        checks++; if (ex_storeData !== 32'hAA) begin errors++; $display("FAIL fwd_mem_store got=%h exp=aa", ex_storeData); end
        mem_regWrite = 1'b0;
        #1;
        checks++; if (srcA !== 32'hBB) begin errors++; $display("FAIL fwd_wb_srcA got=%h exp=bb", srcA); end
        checks++; if (srcB !== 32'hBB) begin errors++; $display("FAIL fwd_wb_srcB got=%h exp=bb", srcB); end
        wb_regWrite = 1'b0;
        #1;
        checks++; if (srcA !== 32'h11) begin errors++; $display("FAIL fwd_none_srcA got=%h exp=11", srcA); end
    endtask

    task automatic test_x0();
        idle_inputs();
        id_valid = 1'b1;
        tick();
        mem_regWrite = 1'b1; mem_rdAddr = 5'd0; mem_ALUResult = 32'hFFFF;
        wb_regWrite = 1'b1; wb_rdAddr = 5'd0; wb_result = 32'h5555;
        #1;
        checks++; if (srcA !== 32'h0) begin errors++; $display("FAIL x0_srcA got=%h exp=0", srcA); end
        checks++; if (srcB !== 32'h0) begin errors++; $display("FAIL x0_srcB got=%h exp=0", srcB); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_valid = 1'b1; id_memRead = 1'b1; id_regWrite = 1'b1; id_rdAddr = 5'd5;
        tick();
        id_memRead = 1'b0; id_rs1Addr = 5'd5; id_rs2Addr = 5'd6;
        #1;
        checks++; if (loadUseHazard !== 1'b1) begin errors++; $display("FAIL luh_rs1 got=%b exp=1", loadUseHazard); end
        id_rs1Addr = 5'd6; id_rs2Addr = 5'd5;
        #1;
        checks++; if (loadUseHazard !== 1'b1) begin errors++; $display("FAIL luh_rs2 got=%b exp=1", loadUseHazard); end
        id_rs2Addr = 5'd7;
        #1;
        checks++; if (loadUseHazard !== 1'b0) begin errors++; $display("FAIL luh_none got=%b exp=0", loadUseHazard); end
        id_rs2Addr = 5'd5; id_ALUControl = 4'd9; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0 || ALUControl !== 4'd0)
            begin errors++; $display("FAIL luh_flush got=%b/%b/%0d exp=0/0/0", ex_valid, ex_regWrite, ALUControl); end
        checks++; if (loadUseHazard !== 1'b0) begin errors++; $display("FAIL luh_after_flush got=%b exp=0", loadUseHazard); end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        id_valid = 1'b1; id_ALUControl = 4'd4; id_pc = 32'h100; id_rs1Addr = 5'd2; id_rs1Data = 32'h77;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_pc = $urandom; id_rs1Data = $urandom; id_ALUControl = 4'($urandom_range(9));
            id_valid = 1'($urandom); id_ALUSrcA = 2'($urandom);
            tick();
            checks++; if (ALUControl !== 4'd4 || ex_pc !== 32'h100 || srcA !== 32'h77 || ex_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold cyc=%0d got=%0d/%h/%h/%b exp=4/100/77/1", i, ALUControl, ex_pc, srcA, ex_valid); end
        end
        flush = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ALUControl !== 4'd0)
            begin errors++; $display("FAIL stall_flush got=%b/%h/%0d exp=0/0/0", ex_valid, ex_pc, ALUControl); end
        flush = 1'b0; stall = 1'b0; id_valid = 1'b1; id_pc = 32'h300;
        tick();
        stall = 1'b1; reset = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0)
            begin errors++; $display("FAIL stall_reset got=%b/%h exp=0/0", ex_valid, ex_pc); end
        reset = 1'b0; stall = 1'b0;
    endtask

    task automatic test_capture_bypass();
        idle_inputs();
        id_valid = 1'b1; id_rs2Addr = 5'd4; id_rs2Data = 32'h0;
        wb_regWrite = 1'b1; wb_rdAddr = 5'd4; wb_result = 32'h1234;
        id_ALUSrcA = 2'd1; id_pc = 32'h2000; id_ALUSrcB = 1'b1; id_immExt = 32'h40;
        tick();
        wb_regWrite = 1'b0;
        #1;
        checks++; if (ex_storeData !== 32'h1234) begin errors++; $display("FAIL bypass_store got=%h exp=1234", ex_storeData); end
        checks++; if (srcA !== 32'h2000) begin errors++; $display("FAIL bypass_srcA_pc got=%h exp=2000", srcA); end
        checks++; if (srcB !== 32'h40) begin errors++; $display("FAIL bypass_srcB_imm got=%h exp=40", srcB); end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] e_a, e_b, e_st;
        logic            e_luh;
        idle_inputs();
        reset = 1'b1;
        tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 1; r < 8; r++) regs[r] = $urandom;
            regs[0] = '0;
            reset = ($urandom_range(31) == 0);
            flush = ($urandom_range(7) == 0);
            stall = ($urandom_range(3) == 0);
            id_valid = 1'($urandom); id_pc = $urandom; id_immExt = $urandom;
            id_rs1Addr = 5'($urandom_range(7)); id_rs2Addr = 5'($urandom_range(7));
            id_rdAddr = 5'($urandom_range(7));
            id_rs1Data = regs[id_rs1Addr]; id_rs2Data = regs[id_rs2Addr];
            id_ALUControl = 4'($urandom_range(9)); id_ALUSrcA = 2'($urandom);
            id_ALUSrcB = 1'($urandom); id_regWrite = 1'($urandom); id_memRead = 1'($urandom);
            mem_regWrite = 1'($urandom); mem_rdAddr = 5'($urandom_range(7)); mem_ALUResult = $urandom;
            wb_regWrite = 1'($urandom); wb_rdAddr = 5'($urandom_range(7)); wb_result = $urandom;
            #1;
            e_st  = newest(m.rs2, m.v2);
            e_a   = (m.sa == 2'd0) ? newest(m.rs1, m.v1) : (m.sa == 2'd1) ? m.pc : '0;
            e_b   = m.sb ? m.imm : e_st;
            e_luh = m.valid && m.mr && m.rd != 0 && (m.rd == id_rs1Addr || m.rd == id_rs2Addr);
            checks++; if (srcA !== e_a) begin errors++; $display("FAIL rnd_srcA cyc=%0d got=%h exp=%h", cyc, srcA, e_a); end
            checks++; if (srcB !== e_b) begin errors++; $display("FAIL rnd_srcB cyc=%0d got=%h exp=%h", cyc, srcB, e_b); end
            checks++; if (ex_storeData !== e_st) begin errors++; $display("FAIL rnd_store cyc=%0d got=%h exp=%h", cyc, ex_storeData, e_st); end
            checks++; if (loadUseHazard !== e_luh) begin errors++; $display("FAIL rnd_luh cyc=%0d got=%b exp=%b", cyc, loadUseHazard, e_luh); end
            checks++; if ({ex_valid, ex_regWrite, ex_memRead, ALUControl, ex_rdAddr} !== {m.valid, m.rw, m.mr, m.op, m.rd})
                begin errors++; $display("FAIL rnd_ctrl cyc=%0d got=%b%b%b/%0d/%0d exp=%b%b%b/%0d/%0d", cyc,
                    ex_valid, ex_regWrite, ex_memRead, ALUControl, ex_rdAddr, m.valid, m.rw, m.mr, m.op, m.rd); end
            checks++; if (ex_pc !== m.pc || ex_immExt !== m.imm)
                begin errors++; $display("FAIL rnd_pcimm cyc=%0d got=%h/%h exp=%h/%h", cyc, ex_pc, ex_immExt, m.pc, m.imm); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        m = bubble();
        idle_inputs();
        test_reset();
        test_basic_load();
        test_forward_priority();
        test_x0();
        test_load_use();
        test_stall_flush();
        test_capture_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
